// File: rtl/mesh_mac_cell_pkg.sv
// Shared constants for mesh MAC cells: result width, FSM encoding and the
// saturating add used by the accumulator.
package mesh_mac_cell_pkg;

    localparam int RES_W = 12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [RES_W-1:0] SAT = 12'hFFF;

    // Inputs never exceed 2*SAT, so the carry bit alone signals overflow.
    function automatic logic [RES_W-1:0] sat_clip(input logic [RES_W:0] s);
        return s[RES_W] ? SAT : s[RES_W-1:0];
    endfunction

endpackage

// File: rtl/mesh_mac_cell_if.sv
// Operand/result bundle of one mesh MAC cell; the slave side is the cell.
interface mesh_mac_cell_if #(parameter int AW = 4);
    import mesh_mac_cell_pkg::*;

    logic              START;
    logic              VALID_IN;
    logic [AW-1:0]     A_IN;
    logic [AW-1:0]     B_IN;
    logic [AW-1:0]     A_OUT;
    logic [AW-1:0]     B_OUT;
    logic              VALID_OUT;
    logic [RES_W-1:0]  RES;
    logic              RES_EN;
    logic              OVF;
    logic              BUSY;

    modport master (
        output START, VALID_IN, A_IN, B_IN,
        input  A_OUT, B_OUT, VALID_OUT, RES, RES_EN, OVF, BUSY
    );

    modport slave (
        input  START, VALID_IN, A_IN, B_IN,
        output A_OUT, B_OUT, VALID_OUT, RES, RES_EN, OVF, BUSY
    );
endinterface

// File: rtl/mesh_mac_cell_mult_unsigned.sv
// Combinational unsigned W x W -> 2W multiplier shared by the mesh cells.
module mult_unsigned #(
    parameter int W = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);
    assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
endmodule

// File: rtl/mesh_mac_cell.sv
// Mesh processing element: forwards operands east/south and accumulates K
// saturating products, strobing the finished dot product for one cycle.
module mesh_mac_cell
    import mesh_mac_cell_pkg::*;
#(
    parameter int K  = 3,
    parameter int AW = 4
) (
    input  logic            CLK,
    input  logic            RST,
    mesh_mac_cell_if.slave  bus
);
    localparam int CW = $clog2(K + 1);
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    logic [2*AW-1:0]  prod;
    logic [RES_W:0]   prod_ext;
    logic [RES_W:0]   sum;
    logic [RES_W-1:0] sum_sat;

    logic [1:0]       state;
    logic [RES_W-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [RES_W-1:0] res;
    logic             res_en;
    logic             ovf;

    logic [AW-1:0]    a_q;
    logic [AW-1:0]    b_q;
    logic             vld_q;

    mult_unsigned #(.W(AW)) u_mult (
        .a (bus.A_IN),
        .b (bus.B_IN),
        .p (prod)
    );

    assign prod_ext = {{(RES_W + 1 - 2*AW){1'b0}}, prod};
    assign sum      = {1'b0, acc} + prod_ext;
    assign sum_sat  = sat_clip(sum);

    // Forwarding path is independent of the FSM; operands hold across bubbles.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q   <= '0;
            b_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= bus.VALID_IN;
            if (bus.VALID_IN) begin
                a_q <= bus.A_IN;
                b_q <= bus.B_IN;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_IDLE;
            acc    <= '0;
            cnt    <= '0;
            res    <= '0;
            res_en <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            res_en <= 1'b0;
            // START wins in every state; a pair arriving with it is term one.
            if (bus.START) begin
                ovf <= 1'b0;
                if (bus.VALID_IN) begin
                    acc <= prod_ext[RES_W-1:0];
                    cnt <= CW'(1);
                    if (K == 1) begin
                        state  <= ST_DONE;
                        res    <= prod_ext[RES_W-1:0];
                        res_en <= 1'b1;
                    end else begin
                        state <= ST_ACC;
                    end
                end else begin
                    acc   <= '0;
                    cnt   <= '0;
                    state <= ST_ACC;
                end
            end else begin
                case (state)
                    ST_ACC: begin
                        if (bus.VALID_IN) begin
                            acc <= sum_sat;
                            ovf <= ovf | sum[RES_W];
                            cnt <= cnt + CW'(1);
                            if (cnt == LAST) begin
                                state  <= ST_DONE;
                                res    <= sum_sat;
                                res_en <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.A_OUT     = a_q;
    assign bus.B_OUT     = b_q;
    assign bus.VALID_OUT = vld_q;
    assign bus.RES       = res;
    assign bus.RES_EN    = res_en;
    assign bus.OVF       = ovf;
    assign bus.BUSY      = (state == ST_ACC);

endmodule

// File: tb/tb_mesh_mac_cell.sv
// Directed bench: a K=3/AW=4 cell and a K=2/AW=6 cell on a shared clock/reset.
module tb_mesh_mac_cell;
    logic CLK;
    logic RST;

    mesh_mac_cell_if #(.AW(4)) if0 ();
    mesh_mac_cell_if #(.AW(6)) if1 ();

    mesh_mac_cell #(.K(3), .AW(4)) u_dut (.CLK(CLK), .RST(RST), .bus(if0));
    mesh_mac_cell #(.K(2), .AW(6)) u_dut6 (.CLK(CLK), .RST(RST), .bus(if1));

    int checks = 0;
    int errors = 0;
    int strobes0 = 0;
    int strobes1 = 0;
    int base;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge, then sample 1ns later; counts strobes of both cells.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (if0.RES_EN === 1'b1) strobes0++;
        if (if1.RES_EN === 1'b1) strobes1++;
    endtask

    task automatic drv(input logic s, input logic v, input logic [3:0] a, input logic [3:0] b);
        if0.START = s; if0.VALID_IN = v; if0.A_IN = a; if0.B_IN = b;
        tick();
    endtask

    task automatic drv6(input logic s, input logic v, input logic [5:0] a, input logic [5:0] b);
        if1.START = s; if1.VALID_IN = v; if1.A_IN = a; if1.B_IN = b;
        tick();
    endtask

    initial begin
        RST = 1'b1;
        if0.START = 0; if0.VALID_IN = 0; if0.A_IN = 0; if0.B_IN = 0;
        if1.START = 0; if1.VALID_IN = 0; if1.A_IN = 0; if1.B_IN = 0;
        tick();
        tick();
        chk("rst_res",    32'(if0.RES), 0);
        chk("rst_res_en", 32'(if0.RES_EN), 0);
        chk("rst_busy",   32'(if0.BUSY), 0);
        chk("rst_ovf",    32'(if0.OVF), 0);
        chk("rst_aout",   32'(if0.A_OUT), 0);
        chk("rst_vout",   32'(if0.VALID_OUT), 0);
        RST = 1'b0;
        tick();

        // back-to-back: 1*4 + 2*5 + 3*6 = 32
        base = strobes0;
        drv(1, 1, 1, 4);
        chk("b2b_busy1", 32'(if0.BUSY), 1);
        drv(0, 1, 2, 5);
        chk("b2b_no_early", 32'(strobes0 - base), 0);
        drv(0, 1, 3, 6);
        chk("b2b_res_en", 32'(if0.RES_EN), 1);
        chk("b2b_res",    32'(if0.RES), 32);
        chk("b2b_ovf",    32'(if0.OVF), 0);
        chk("b2b_busy_done", 32'(if0.BUSY), 0);
        drv(0, 0, 0, 0);
        chk("b2b_pulse_len", 32'(if0.RES_EN), 0);
        chk("b2b_res_hold",  32'(if0.RES), 32);
        chk("b2b_strobes",   32'(strobes0 - base), 1);

        // bubbles of 2 idle cycles; garbage operands while invalid
        base = strobes0;
        drv(1, 1, 1, 4);
        drv(0, 0, 15, 15);
        drv(0, 0, 15, 15);
        drv(0, 1, 2, 5);
        drv(0, 0, 15, 15);
        drv(0, 0, 15, 15);
        chk("gap_no_early", 32'(strobes0 - base), 0);
        chk("gap_busy",     32'(if0.BUSY), 1);
        drv(0, 1, 3, 6);
        chk("gap_res_en", 32'(if0.RES_EN), 1);
        chk("gap_res",    32'(if0.RES), 32);
        drv(0, 0, 0, 0);

        // saturation on the AW=6, K=2 cell: 3969*2 = 7938 -> 4095
        drv6(1, 1, 63, 63);
        drv6(0, 1, 63, 63);
        chk("sat_res_en", 32'(if1.RES_EN), 1);
        chk("sat_res",    32'(if1.RES), 4095);
        chk("sat_ovf",    32'(if1.OVF), 1);
        drv6(0, 0, 0, 0);
        chk("sat_ovf_hold", 32'(if1.OVF), 1);
        drv6(1, 1, 1, 1);
        chk("sat_ovf_clr", 32'(if1.OVF), 0);
        drv6(0, 1, 1, 1);
        chk("sat_res2", 32'(if1.RES), 2);
        chk("sat_ovf2", 32'(if1.OVF), 0);
        chk("sat_strobes", 32'(strobes1), 2);
        drv6(0, 0, 0, 0);

        // forwarding and VALID_IN in IDLE without START
        base = strobes0;
        drv(0, 1, 9, 5);
        chk("fwd_a",  32'(if0.A_OUT), 9);
        chk("fwd_b",  32'(if0.B_OUT), 5);
        chk("fwd_v1", 32'(if0.VALID_OUT), 1);
        chk("fwd_idle_busy", 32'(if0.BUSY), 0);
        drv(0, 0, 3, 3);
        chk("fwd_a_hold", 32'(if0.A_OUT), 9);
        chk("fwd_b_hold", 32'(if0.B_OUT), 5);
        chk("fwd_v0", 32'(if0.VALID_OUT), 0);
        drv(0, 1, 7, 7);
        drv(0, 0, 0, 0);
        chk("fwd_no_strobe", 32'(strobes0 - base), 0);
        chk("fwd_res_hold",  32'(if0.RES), 32);

        // restart mid-sum: abandoned (2,2) never strobes
        base = strobes0;
        drv(1, 1, 2, 2);
        drv(1, 1, 1, 1);
        drv(0, 1, 1, 1);
        chk("rs_no_early", 32'(strobes0 - base), 0);
        drv(0, 1, 1, 1);
        chk("rs_res", 32'(if0.RES), 3);
        chk("rs_strobes", 32'(strobes0 - base), 1);

        // START overlapping DONE: 1+4+9 = 14, then 2+2+2 = 6
        drv(1, 1, 1, 1);
        drv(0, 1, 2, 2);
        drv(0, 1, 3, 3);
        chk("ovl_res_en", 32'(if0.RES_EN), 1);
        chk("ovl_res",    32'(if0.RES), 14);
        drv(1, 1, 2, 1);
        chk("ovl_busy",   32'(if0.BUSY), 1);
        chk("ovl_hold",   32'(if0.RES), 14);
        drv(0, 1, 2, 1);
        drv(0, 1, 2, 1);
        chk("ovl_res2",   32'(if0.RES), 6);
        chk("ovl_en2",    32'(if0.RES_EN), 1);
        drv(0, 0, 0, 0);

        // async reset after the second term
        base = strobes0;
        drv(1, 1, 1, 1);
        drv(0, 1, 1, 1);
        if0.VALID_IN = 1'b1;
        #2 RST = 1'b1;
        #1;
        chk("arst_res",  32'(if0.RES), 0);
        chk("arst_busy", 32'(if0.BUSY), 0);
        chk("arst_aout", 32'(if0.A_OUT), 0);
        chk("arst_vout", 32'(if0.VALID_OUT), 0);
        tick();
        tick();
        chk("arst_no_strobe", 32'(strobes0 - base), 0);
        RST = 1'b0;
        drv(0, 1, 1, 1);
        drv(0, 0, 0, 0);
        chk("arst_idle", 32'(strobes0 - base), 0);
        drv(1, 1, 1, 1);
        drv(0, 1, 1, 1);
        drv(0, 1, 1, 1);
        chk("arst_res_en", 32'(if0.RES_EN), 1);
        chk("arst_res3",   32'(if0.RES), 3);
        drv(0, 0, 0, 0);
        chk("arst_strobes", 32'(strobes0 - base), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mesh_mac_cell.md
# mesh_mac_cell

Processing element of the 2D-mesh matrix multiplier. Each cell takes operands from its west (A) and north (B) neighbours, forwards them east and south through one register stage, and accumulates K products into a 12-bit dot product. When the dot product completes, the cell issues a one-cycle load strobe with the result. This strobe drives the cell's 12-bit result register directly (its EN and D inputs).

## Interface
- K, default 3: number of products per dot product (matrix inner dimension); K ≥ 1.
- AW, default 4: operand width; 2·AW ≤ 12.
- CLK  in  1  master clock, rising edge.
- RST  in  1  master reset, asynchronous, active-high.
- START  in  1  begin new dot product: clears accumulator, counter and OVF.
- VALID_IN  in  1  A_IN/B_IN carry a valid operand pair this cycle.
- A_IN  in  AW  operand from west neighbour, unsigned.
- B_IN  in  AW  operand from north neighbour, unsigned.
- A_OUT  out  AW  registered A_IN to east neighbour.
- B_OUT  out  AW  registered B_IN to south neighbour.
- VALID_OUT  out  1  registered VALID_IN.
- RES  out  12  dot-product result, connects to result register D.
- RES_EN  out  1  one-cycle load strobe, connects to result register EN.
- OVF  out  1  sticky saturation flag for the current dot product.
- BUSY  out  1  high in ACC state.

## Operation
- Reset values: A_OUT=0, B_OUT=0, VALID_OUT=0, RES=0, RES_EN=0, OVF=0, BUSY=0, state IDLE, accumulator=0, counter=0.
- Forwarding runs independently of the FSM.
  - VALID_OUT<=VALID_IN every cycle.
  - A_OUT/B_OUT load A_IN/B_IN only when VALID_IN=1, otherwise hold.
- Product = A_IN·B_IN, unsigned, 2·AW bits, zero-extended to 13 bits.
- Accumulate: sum = acc + product, computed in 13 bits.
  - If sum > 4095: acc<=4095 and OVF<=1 (saturate).
  - Otherwise acc<=sum.
- Once at 4095, the accumulator stays at 4095 until the next START.
- FSM states: IDLE, ACC, DONE.
  - IDLE: START=1 → ACC; acc, counter and OVF cleared. If VALID_IN=1 in the same cycle, that pair counts as the first term (acc<=product, counter<=1). VALID_IN without START is forwarded only, never accumulated.
  - ACC: each VALID_IN=1 cycle accumulates and increments the counter. Cycles with VALID_IN=0 leave acc and counter unchanged, so bubbles are allowed. The cycle carrying term K → DONE.
  - DONE: RES<=final acc (includes term K), RES_EN=1 for exactly this cycle. Next state is IDLE, or ACC when START=1 (restart rules as in IDLE).
- START in ACC: abandon the current sum and restart (clear, with the simultaneous-term rule). No RES_EN is issued for the abandoned sum.
- K=1: the START+VALID cycle goes straight to DONE.
- RES holds its value between strobes.
- OVF holds until the next START or RST.

## Timing
- Forwarding latency: 1 cycle (A_IN at edge t appears on A_OUT after edge t).
- Result latency: term K sampled at edge t → RES/RES_EN valid after edge t, during cycle t+1. The result register captures at edge t+1.
- Minimum dot-product period: K+1 cycles (K terms + DONE), or K cycles when START overlaps DONE.
- RST asserted mid-operation: all outputs and state return to reset values immediately, with no RES_EN. Operation resumes only on a fresh START after RST deasserts.

## Structure
- A shared package holds:
  - RES_W=12.
  - The FSM state encoding (IDLE=2'd0, ACC=2'd1, DONE=2'd2).
  - The saturation constant 12'hFFF.
- One sub-module: mult_unsigned (combinational AW×AW → 2·AW unsigned multiplier), reusable by other mesh cells.
- The FSM, counter ($clog2(K+1) bits), accumulator and forwarding registers live in mesh_mac_cell.

## Test plan
- K=3, AW=4: START+VALID with (1,4), then VALID (2,5), (3,6) on consecutive cycles → RES=32, RES_EN high exactly one cycle after the third pair, OVF=0, BUSY low afterwards.
- Same operands as above with VALID_IN gaps of 2 idle cycles between pairs → RES=32, RES_EN one cycle after the third valid pair; no strobe earlier.
- AW=6, K=2: pairs (63,63),(63,63) → sum 7938 saturates; RES=4095, OVF=1. Next START with (1,1),(1,1) → RES=2, OVF=0.
- Forwarding: VALID_IN=1 with A=9, B=5, then VALID_IN=0 with A=3, B=3 → A_OUT/B_OUT show 9/5 and stay 9/5; VALID_OUT tracks VALID_IN delayed by one cycle. VALID_IN in IDLE without START → no accumulation, no RES_EN.
- Restart: START, one term (2,2), START again with (1,1), then (1,1),(1,1) → single RES_EN with RES=3; no strobe for the abandoned sum. START overlapping DONE → RES_EN still pulses and the new sum proceeds.
- RST asserted asynchronously after the second term of a K=3 sum → all outputs 0 immediately, no RES_EN. After release, a full sequence of (1,1)×3 → RES=3.
